// File: rtl/control101.sv
// Multi-cycle controller: each instruction runs FETCH/DECODE/EXEC/WB and drives a register-bank/ALU datapath.
// Optional feature: define CTRL101_ILLEGAL_TRAP_EN to halt (with illegal=1) on opcodes 7-15.
module control101 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] instr,
  input  logic [7:0]  ULAResult,
  input  logic        FlagZ,
  output logic [7:0]  pc,
  output logic [2:0]  ra1,
  output logic [2:0]  ra2,
  output logic [2:0]  wa3,
  output logic        we3,
  output logic [7:0]  wd3,
  output logic [7:0]  constante,
  output logic [2:0]  ULAControl,
  output logic        select_src,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_ALU_RR = 4'd1;
  localparam logic [3:0] OP_ALU_RI = 4'd2;
  localparam logic [3:0] OP_LI     = 4'd3;
  localparam logic [3:0] OP_BZ     = 4'd4;
  localparam logic [3:0] OP_JMP    = 4'd5;
  localparam logic [3:0] OP_HALT   = 4'd6;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_pc;
  logic [7:0]  w_pc_next;
  logic [23:0] r_ir;
  logic [7:0]  r_result;
  logic        r_zreg;
  logic        r_illegal;
  logic        w_trap;

  logic [3:0]  w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs1;
  logic [2:0]  w_rs2;
  logic [2:0]  w_alu;
  logic [7:0]  w_imm;
  logic        w_is_alu;
  logic        w_writes;
  logic        w_drive_dp;

  assign w_op  = r_ir[23:20];
  assign w_rd  = r_ir[19:17];
  assign w_rs1 = r_ir[16:14];
  assign w_rs2 = r_ir[13:11];
  assign w_alu = r_ir[10:8];
  assign w_imm = r_ir[7:0];

  assign w_is_alu   = (w_op == OP_ALU_RR) || (w_op == OP_ALU_RI);
  assign w_writes   = w_is_alu || (w_op == OP_LI);
  assign w_drive_dp = (r_state == S_DECODE) || (r_state == S_EXEC) || (r_state == S_WB);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= 8'd0;
      r_ir      <= 24'd0;
      r_result  <= 8'd0;
      r_zreg    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_illegal <= r_illegal | w_trap;
      if (r_state == S_FETCH) begin
        r_ir <= instr;
      end
      // zreg only tracks ALU ops so a later BZ sees the last ALU outcome
      if (r_state == S_EXEC) begin
        r_result <= ULAResult;
        if (w_is_alu) begin
          r_zreg <= FlagZ;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_trap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_FETCH;
          w_pc_next    = 8'd0;
        end
      end
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: w_state_next = S_EXEC;
      S_EXEC:   w_state_next = S_WB;
      S_WB: begin
        w_state_next = S_FETCH;
        w_pc_next    = r_pc + 8'd1;
        case (w_op)
          OP_BZ: begin
            if (r_zreg) begin
              w_pc_next = w_imm;
            end
          end
          OP_JMP: w_pc_next = w_imm;
          OP_HALT: begin
            w_state_next = S_HALTED;
            w_pc_next    = r_pc;
          end
          default: begin
`ifdef CTRL101_ILLEGAL_TRAP_EN
            if (w_op > OP_HALT) begin
              w_state_next = S_HALTED;
              w_pc_next    = r_pc;
              w_trap       = 1'b1;
            end
`endif
          end
        endcase
      end
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ra1        = 3'd0;
    ra2        = 3'd0;
    wa3        = 3'd0;
    wd3        = 8'd0;
    constante  = 8'd0;
    ULAControl = 3'd0;
    select_src = 1'b0;
    we3        = 1'b0;
    if (w_drive_dp) begin
      ra1        = w_rs1;
      ra2        = w_rs2;
      wa3        = w_rd;
      constante  = w_imm;
      ULAControl = w_alu;
      select_src = (w_op == OP_ALU_RI);
      wd3        = w_is_alu ? r_result : w_imm;
      we3        = (r_state == S_WB) && w_writes;
    end
  end

  assign pc      = r_pc;
  assign busy    = (r_state == S_FETCH) || w_drive_dp;
  assign halted  = (r_state == S_HALTED);
  assign illegal = r_illegal;

endmodule

// File: tb/tb_control101.sv
// Directed self-checking bench for control101: ROM and datapath responses are modelled by the bench.
module tb_control101;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] instr;
  logic [7:0]  ULAResult;
  logic        FlagZ;
  logic [7:0]  pc;
  logic [2:0]  ra1, ra2, wa3;
  logic        we3;
  logic [7:0]  wd3;
  logic [7:0]  constante;
  logic [2:0]  ULAControl;
  logic        select_src;
  logic        busy, halted, illegal;

  logic [23:0] rom [0:255];
  logic [40:0] all_outs;
  int          n_checks;
  int          n_fail;

  control101 dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr),
    .ULAResult(ULAResult), .FlagZ(FlagZ), .pc(pc),
    .ra1(ra1), .ra2(ra2), .wa3(wa3), .we3(we3), .wd3(wd3),
    .constante(constante), .ULAControl(ULAControl), .select_src(select_src),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  assign instr    = rom[pc];
  assign all_outs = {pc, ra1, ra2, wa3, we3, wd3, constante, ULAControl, select_src, busy, halted, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] enc(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                      input logic [2:0] rs2, input logic [2:0] alu, input logic [7:0] imm);
    return {op, rd, rs1, rs2, alu, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 24'd0;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    tick();
    rst   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    ULAResult = 8'd0;
    FlagZ     = 1'b0;
    do_reset();
    n_checks++;
    if (all_outs !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    tick();
    n_checks++;
    if (all_outs !== 41'd0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h expected 0", all_outs);
    end
    $display("test_reset done");
  endtask

  task automatic test_program();
    logic       exp_we;
    logic [7:0] exp_wd;
    clear_rom();
    rom[0] = enc(4'd3, 3'd1, 3'd0, 3'd0, 3'd0, 8'd5);
    rom[1] = enc(4'd3, 3'd2, 3'd0, 3'd0, 3'd0, 8'd3);
    rom[2] = enc(4'd1, 3'd3, 3'd1, 3'd2, 3'd2, 8'd0);
    rom[3] = enc(4'd6, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0);
    ULAResult = 8'd8;
    FlagZ     = 1'b0;
    do_reset();
    pulse_start();
    for (int c = 1; c <= 16; c++) begin
      exp_we = (c == 4) || (c == 8) || (c == 12);
      exp_wd = (c == 4) ? 8'd5 : (c == 8) ? 8'd3 : 8'd8;
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL prog_busy c%0d: got %b expected 1", c, busy);
      end
      n_checks++;
      if (we3 !== exp_we) begin
        n_fail++;
        $display("FAIL prog_we3 c%0d: got %b expected %b", c, we3, exp_we);
      end
      if (exp_we) begin
        n_checks++;
        if (wd3 !== exp_wd) begin
          n_fail++;
          $display("FAIL prog_wd3 c%0d: got %0d expected %0d", c, wd3, exp_wd);
        end
      end
      if (c == 10) begin
        n_checks++;
        if ({ra1, ra2, wa3, ULAControl, select_src} !== {3'd1, 3'd2, 3'd3, 3'd2, 1'b0}) begin
          n_fail++;
          $display("FAIL prog_decode: got %h expected %h", {ra1, ra2, wa3, ULAControl, select_src},
                   {3'd1, 3'd2, 3'd3, 3'd2, 1'b0});
        end
      end
      tick();
    end
    n_checks++;
    if ({halted, busy, we3, pc} !== {1'b1, 1'b0, 1'b0, 8'd3}) begin
      n_fail++;
      $display("FAIL prog_halted: got h=%b b=%b we=%b pc=%0d expected h=1 b=0 we=0 pc=3", halted, busy, we3, pc);
    end
    pulse_start();
    tick();
    n_checks++;
    if ({halted, busy, pc} !== {1'b1, 1'b0, 8'd3}) begin
      n_fail++;
      $display("FAIL halted_start_ignored: got h=%b b=%b pc=%0d expected h=1 b=0 pc=3", halted, busy, pc);
    end
    $display("test_program done");
  endtask

  task automatic test_branch();
    // taken: zreg set by ALU_RI must survive an intervening LI
    clear_rom();
    rom[0] = enc(4'd2, 3'd1, 3'd1, 3'd0, 3'd0, 8'h00);
    rom[1] = enc(4'd3, 3'd5, 3'd0, 3'd0, 3'd0, 8'd7);
    rom[2] = enc(4'd4, 3'd0, 3'd0, 3'd0, 3'd0, 8'h40);
    ULAResult = 8'd0;
    FlagZ     = 1'b1;
    do_reset();
    pulse_start();
    tick();
    n_checks++;
    if ({select_src, constante, ra1, wa3} !== {1'b1, 8'h00, 3'd1, 3'd1}) begin
      n_fail++;
      $display("FAIL alu_ri_decode: got sel=%b k=%h ra1=%0d wa3=%0d expected sel=1 k=00 ra1=1 wa3=1",
               select_src, constante, ra1, wa3);
    end
    tick();
    tick();
    n_checks++;
    if ({we3, wd3} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL alu_ri_wb: got we=%b wd=%h expected we=1 wd=00", we3, wd3);
    end
    FlagZ     = 1'b0;
    ULAResult = 8'h55;
    for (int i = 0; i < 9; i++) tick();
    n_checks++;
    if ({pc, busy} !== {8'h40, 1'b1}) begin
      n_fail++;
      $display("FAIL bz_taken: got pc=%h busy=%b expected pc=40 busy=1", pc, busy);
    end
    // not taken
    clear_rom();
    rom[0] = enc(4'd2, 3'd1, 3'd1, 3'd0, 3'd0, 8'h00);
    rom[1] = enc(4'd4, 3'd0, 3'd0, 3'd0, 3'd0, 8'h40);
    ULAResult = 8'd3;
    FlagZ     = 1'b0;
    do_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if ({select_src, constante} !== {1'b0, 8'h40}) begin
      n_fail++;
      $display("FAIL bz_decode: got sel=%b k=%h expected sel=0 k=40", select_src, constante);
    end
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (pc !== 8'd2) begin
      n_fail++;
      $display("FAIL bz_not_taken: got pc=%h expected 02", pc);
    end
    $display("test_branch done");
  endtask

  task automatic test_jmp_wrap();
    clear_rom();
    rom[0]   = enc(4'd5, 3'd0, 3'd0, 3'd0, 3'd0, 8'hFF);
    rom[255] = 24'd0;
    do_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if ({pc, busy} !== {8'hFF, 1'b1}) begin
      n_fail++;
      $display("FAIL jmp_target: got pc=%h busy=%b expected pc=ff busy=1", pc, busy);
    end
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if ({pc, busy} !== {8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL pc_wrap: got pc=%h busy=%b expected pc=00 busy=1", pc, busy);
    end
    $display("test_jmp_wrap done");
  endtask

  task automatic test_reset_in_wb();
    clear_rom();
    rom[0] = enc(4'd3, 3'd4, 3'd0, 3'd0, 3'd0, 8'd9);
    do_reset();
    pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({pc, busy} !== {8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL start_while_busy: got pc=%h busy=%b expected pc=00 busy=1", pc, busy);
    end
    tick();
    n_checks++;
    if ({we3, wd3, wa3} !== {1'b1, 8'd9, 3'd4}) begin
      n_fail++;
      $display("FAIL li_wb: got we=%b wd=%0d wa=%0d expected we=1 wd=9 wa=4", we3, wd3, wa3);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (all_outs !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_in_wb: got %h expected 0", all_outs);
    end
    tick();
    n_checks++;
    if (all_outs !== 41'd0) begin
      n_fail++;
      $display("FAIL idle_after_wb_reset: got %h expected 0", all_outs);
    end
    $display("test_reset_in_wb done");
  endtask

  task automatic test_illegal();
    clear_rom();
    rom[0] = enc(4'hA, 3'd1, 3'd0, 3'd0, 3'd0, 8'h12);
    do_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (we3 !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_no_write: got we=%b expected 0", we3);
    end
    tick();
    n_checks++;
`ifdef CTRL101_ILLEGAL_TRAP_EN
    if ({halted, illegal, busy, pc} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL illegal_trap: got h=%b ill=%b b=%b pc=%h expected h=1 ill=1 b=0 pc=00",
               halted, illegal, busy, pc);
    end
`else
    if ({halted, illegal, busy, pc} !== {1'b0, 1'b0, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL illegal_as_nop: got h=%b ill=%b b=%b pc=%h expected h=0 ill=0 b=1 pc=01",
               halted, illegal, busy, pc);
    end
`endif
    $display("test_illegal done");
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    ULAResult = 8'd0;
    FlagZ     = 1'b0;
    test_reset();
    test_program();
    test_branch();
    test_jmp_wrap();
    test_reset_in_wb();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
